// File: rtl/fifo_link_pkg.sv
// Shared constants for the CDR FIFO link between the RHS2116 capture path and
// the 100 MHz system domain.
package fifo_link_pkg;

    localparam int unsigned RHS2116_FRAME_WORDS = 16;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned FRAME_WORDS = RHS2116_FRAME_WORDS;
    localparam int unsigned IDX_WIDTH   = 16;
    localparam int unsigned CNT_WIDTH   = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer with occupancy output; the head entry drives
// the stream and stays put until it is popped.
module skid_buffer2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop_ok;

    assign pop_ok     = pop && head_valid;
    assign head_valid = (occ != 2'd0);
    assign head_data  = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    mem1 <= push_data;
                end else begin
                    mem0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side consumer of the CDR async FIFO: credit-based popping into a
// 2-entry buffer, frame word tagging, and frame/error statistics.
module fifo_frame_reader
    import fifo_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = fifo_link_pkg::DATA_WIDTH,
    parameter int unsigned FRAME_WORDS = fifo_link_pkg::FRAME_WORDS,
    parameter int unsigned IDX_WIDTH   = fifo_link_pkg::IDX_WIDTH,
    parameter int unsigned CNT_WIDTH   = fifo_link_pkg::CNT_WIDTH
) (
    input  logic                  clk_rd,
    input  logic                  rst_rd,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic [IDX_WIDTH-1:0]  m_idx,
    input  logic                  resync,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  err_sticky
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_WORDS - 1);

    logic                 inflight;
    logic                 pop;
    logic                 push;
    logic                 stray;
    occ_t                 occ;
    logic [2:0]           credit_used;
    logic [IDX_WIDTH-1:0] idx;

    assign pop   = m_valid && m_ready;
    assign push  = fifo_valid && inflight;
    assign stray = fifo_valid && !inflight;

    // Credits: buffered words plus the outstanding read, less the word leaving now.
    always_comb begin
        credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en  = !fifo_empty && (credit_used < 3'd2);
    end

    skid_buffer2 #(
        .WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk_rd),
        .rst       (rst_rd),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_data),
        .head_valid(m_valid),
        .occ       (occ)
    );

    always_ff @(posedge clk_rd) begin
        if (rst_rd) begin
            inflight   <= 1'b0;
            idx        <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (resync) begin
                idx <= '0;
            end else if (pop) begin
                if (idx == LAST_IDX) begin
                    idx       <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (stray) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                err_sticky <= 1'b1;
            end
        end
    end

    // Frame markers qualified by m_valid so an empty output shows no tags.
    assign m_idx   = idx;
    assign m_first = m_valid && (idx == '0);
    assign m_last  = m_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a behavioural FIFO read port that
// answers each rd_en with fifo_valid one cycle later.
module tb_fifo_frame_reader;
    import fifo_link_pkg::*;

    logic        clk_rd = 1'b0;
    logic        rst_rd = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_first;
    logic        m_last;
    logic [15:0] m_idx;
    logic        resync = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        err_sticky;

    always #5 clk_rd = ~clk_rd;

    fifo_frame_reader #(
        .DATA_WIDTH (32),
        .FRAME_WORDS(16),
        .IDX_WIDTH  (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_rd    (clk_rd),
        .rst_rd    (rst_rd),
        .fifo_dout (fifo_dout),
        .fifo_valid(fifo_valid),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_first   (m_first),
        .m_last    (m_last),
        .m_idx     (m_idx),
        .resync    (resync),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .err_sticky(err_sticky)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] idx;
        logic        first;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] src_word;
    logic [31:0] sent_q[$];
    beat_t       got_q[$];
    bit          stray_next = 1'b0;
    logic [31:0] stray_word;
    int          rd_count = 0;

    logic        s_rd, s_valid, s_ready;
    logic [31:0] s_data;
    logic [15:0] s_idx, s_frame;
    logic [1:0]  s_occ;

    // One clock cycle: sample this cycle's outputs, then act as the FIFO read port.
    task automatic tick();
        beat_t b;
        #1;
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_ready = m_ready;
        s_data  = m_data;
        s_idx   = m_idx;
        s_frame = frame_cnt;
        s_occ   = dut.u_buf.occ;
        if (s_rd) rd_count++;
        if (m_valid && m_ready) begin
            b.data  = m_data;
            b.idx   = m_idx;
            b.first = m_first;
            b.last  = m_last;
            got_q.push_back(b);
        end
        @(posedge clk_rd);
        @(negedge clk_rd);
        fifo_valid = 1'b0;
        if (s_rd) begin
            fifo_valid = 1'b1;
            fifo_dout  = src_word;
            sent_q.push_back(src_word);
            src_word   = src_word + 32'd1;
        end else if (stray_next) begin
            fifo_valid = 1'b1;
            fifo_dout  = stray_word;
            stray_next = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_rd     = 1'b1;
        fifo_empty = 1'b1;
        m_ready    = 1'b0;
        resync     = 1'b0;
        stray_next = 1'b0;
        tick();
        tick();
        rst_rd     = 1'b0;
        fifo_valid = 1'b0;
        sent_q.delete();
        got_q.delete();
        rd_count = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        checks++; if (m_first !== 1'b0) begin failures++; $display("FAIL reset_m_first got=%b exp=0", m_first); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (m_idx !== 16'h0) begin failures++; $display("FAIL reset_m_idx got=%0d exp=0", m_idx); end
        checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (err_cnt !== 16'h0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
    endtask

    task automatic test_stream();
        do_reset();
        src_word   = 32'h1000;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) begin
                checks++; if (s_rd !== 1'b1) begin failures++; $display("FAIL stream_rd_c0 got=%b exp=1", s_rd); end
            end
            checks++;
            if (s_valid !== (c >= 2)) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, s_valid, (c >= 2)); end
            if (c == 17) begin
                checks++; if (s_frame !== 16'd0) begin failures++; $display("FAIL stream_frame_c17 got=%0d exp=0", s_frame); end
            end
            if (c == 18) begin
                checks++; if (s_frame !== 16'd1) begin failures++; $display("FAIL stream_frame_c18 got=%0d exp=1", s_frame); end
            end
        end
        fifo_empty = 1'b1;
        repeat (4) tick();
        checks++;
        if (got_q.size() < 18) begin
            failures++; $display("FAIL stream_count got=%0d exp>=18", got_q.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                checks++;
                if (got_q[i].data !== 32'h1000 + 32'(i) || got_q[i].idx !== 16'(i % 16) ||
                    got_q[i].first !== (i == 0 || i == 16) || got_q[i].last !== (i == 15)) begin
                    failures++;
                    $display("FAIL stream_word i=%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", i,
                             got_q[i].data, got_q[i].idx, got_q[i].first, got_q[i].last,
                             32'h1000 + 32'(i), i % 16, (i == 0 || i == 16), (i == 15));
                end
            end
        end
        checks++; if (got_q.size() != sent_q.size()) begin failures++; $display("FAIL stream_lost got=%0d exp=%0d", got_q.size(), sent_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        src_word   = 32'h2000;
        fifo_empty = 1'b0;
        m_ready    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c >= 2) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== 32'h2000) begin
                    failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/00002000", c, s_valid, s_data);
                end
            end
        end
        checks++; if (rd_count != 2) begin failures++; $display("FAIL bp_rd_count got=%0d exp=2", rd_count); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL bp_no_pop got=%0d exp=0", got_q.size()); end
        m_ready = 1'b1;
        repeat (8) tick();
        fifo_empty = 1'b1;
        repeat (5) tick();
        checks++; if (got_q.size() != sent_q.size() || sent_q.size() < 8) begin
            failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), sent_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== 32'h2000 + 32'(i)) begin
                failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got_q[i].data, 32'h2000 + 32'(i));
            end
        end
    endtask

    task automatic test_stray();
        bit any_valid;
        do_reset();
        src_word   = 32'h0;
        fifo_empty = 1'b1;
        m_ready    = 1'b1;
        any_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stray_word = 32'hDEAD_0000 + 32'(k);
            stray_next = 1'b1;
            tick(); any_valid |= s_valid;
            tick(); any_valid |= s_valid;
        end
        tick(); any_valid |= s_valid;
        checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL stray_err_cnt got=%0d exp=3", err_cnt); end
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b exp=1", err_sticky); end
        checks++; if (any_valid || got_q.size() != 0) begin failures++; $display("FAIL stray_dropped got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_resync();
        do_reset();
        src_word   = 32'h3000;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            resync = (c == 7);
            tick();
        end
        resync     = 1'b0;
        fifo_empty = 1'b1;
        repeat (4) tick();
        checks++;
        if (got_q.size() < 8) begin
            failures++; $display("FAIL resync_count got=%0d exp>=8", got_q.size());
        end else begin
            checks++; if (got_q[5].data !== 32'h3005 || got_q[5].idx !== 16'd5 || got_q[5].first !== 1'b0) begin
                failures++; $display("FAIL resync_old got=%h/%0d/%b exp=00003005/5/0", got_q[5].data, got_q[5].idx, got_q[5].first);
            end
            checks++; if (got_q[6].data !== 32'h3006 || got_q[6].idx !== 16'd0 || got_q[6].first !== 1'b1) begin
                failures++; $display("FAIL resync_new got=%h/%0d/%b exp=00003006/0/1", got_q[6].data, got_q[6].idx, got_q[6].first);
            end
            checks++; if (got_q[7].idx !== 16'd1) begin failures++; $display("FAIL resync_next got=%0d exp=1", got_q[7].idx); end
        end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL resync_frame got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_random();
        int          cyc;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [15:0] prev_idx;
        do_reset();
        src_word   = 32'h0004_0000;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        while (got_q.size() < 1000 && cyc < 20000) begin
            fifo_empty = (cyc % 2 == 1) || (rd_count >= 1000);
            m_ready    = 1'($urandom_range(0, 1));
            tick();
            checks++; if (s_occ > 2'd2) begin failures++; $display("FAIL rand_occ c=%0d got=%0d exp<=2", cyc, s_occ); end
            if (prev_stall) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== prev_data || s_idx !== prev_idx) begin
                    failures++; $display("FAIL rand_stable c=%0d got=%b/%h/%0d exp=1/%h/%0d", cyc, s_valid, s_data, s_idx, prev_data, prev_idx);
                end
            end
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
            prev_idx   = s_idx;
            cyc++;
        end
        checks++; if (got_q.size() != 1000 || sent_q.size() != 1000) begin
            failures++; $display("FAIL rand_count got=%0d sent=%0d exp=1000", got_q.size(), sent_q.size());
        end
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== sent_q[i] || got_q[i].idx !== 16'(i % 16)) begin
                failures++; $display("FAIL rand_word i=%0d got=%h/%0d exp=%h/%0d", i, got_q[i].data, got_q[i].idx, sent_q[i], i % 16);
            end
        end
        checks++; if (frame_cnt !== 16'd62) begin failures++; $display("FAIL rand_frame got=%0d exp=62", frame_cnt); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        src_word   = 32'h5000;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        repeat (20) tick();
        #1;
        checks++; if (frame_cnt !== 16'd1 || m_valid !== 1'b1 || fifo_rd_en !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got=%0d/%b/%b exp=1/1/1", frame_cnt, m_valid, fifo_rd_en);
        end
        rst_rd = 1'b1;
        tick();
        rst_rd     = 1'b0;
        fifo_empty = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 32'h0 || m_first !== 1'b0 || m_last !== 1'b0 || m_idx !== 16'h0) begin
            failures++; $display("FAIL midrst_stream got=%b/%h/%b/%b/%0d exp=0/0/0/0/0", m_valid, m_data, m_first, m_last, m_idx);
        end
        checks++; if (frame_cnt !== 16'h0 || err_cnt !== 16'h0 || err_sticky !== 1'b0 || fifo_rd_en !== 1'b0) begin
            failures++; $display("FAIL midrst_stats got=%0d/%0d/%b/%b exp=0/0/0/0", frame_cnt, err_cnt, err_sticky, fifo_rd_en);
        end
        checks++; if (fifo_valid !== 1'b1) begin failures++; $display("FAIL midrst_stale_setup got=%b exp=1", fifo_valid); end
        tick();
        #1;
        checks++; if (err_cnt !== 16'd1 || err_sticky !== 1'b1) begin
            failures++; $display("FAIL midrst_err got=%0d/%b exp=1/1", err_cnt, err_sticky);
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_drop got=%b exp=0", m_valid); end
    endtask

    initial begin
        src_word = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stray();
        test_resync();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
